// File: rtl/io_multi_timer.sv
// Multi-channel memory-mapped timer: one prescaled free-running counter, NUM_CHANNELS
// compare channels with level interrupts, and LO/HI register access with a read snapshot.
module io_multi_timer #(
    parameter int NUM_CHANNELS   = 2,
    parameter int TIMER_WIDTH    = 64,
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wrEn,
    input  logic                    rdEn,
    input  logic [4:0]              addr,
    input  logic [31:0]             wrData,
    output logic [31:0]             rdData,
    output logic                    rdValid,
    output logic [NUM_CHANNELS-1:0] timerIRQ,
    output logic                    irqAny
);
    localparam int HI_W = TIMER_WIDTH - 32;

    logic [TIMER_WIDTH-1:0]    mtime_r, mtimeNext_s;
    logic [TIMER_WIDTH-1:0]    cmp_r [NUM_CHANNELS];
    logic [TIMER_WIDTH-1:0]    cmpNext_s [NUM_CHANNELS];
    logic                      enable_r, enableNext_s;
    logic [PRESCALE_WIDTH-1:0] div_r, divNext_s;
    logic [PRESCALE_WIDTH-1:0] prescaleCnt_r, prescaleNext_s;
    logic [HI_W-1:0]           snapshot_r, snapshotNext_s;
    logic [31:0]               rdData_r, rdWord_s;
    logic                      rdValid_r;
    logic [NUM_CHANNELS-1:0]   timerIRQ_r, irqCmp_s;
    logic                      irqAny_r;
    logic                      tick_s;

    // Word address of a channel's LO (hi = 0) or HI (hi = 1) compare register.
    function automatic logic [4:0] chanAddr(input int ch, input logic hi);
        return 5'(32'd4 + 32'd2 * 32'(ch) + 32'(hi));
    endfunction

    // Prescaler, control register and counter next-state; mtime writes override the tick.
    always_comb begin
        tick_s         = enable_r && (prescaleCnt_r == div_r);
        enableNext_s   = enable_r;
        divNext_s      = div_r;
        prescaleNext_s = prescaleCnt_r;
        if (wrEn && (addr == 5'd2)) begin
            enableNext_s   = wrData[0];
            divNext_s      = wrData[16 +: PRESCALE_WIDTH];
            prescaleNext_s = '0;
        end else if (tick_s) begin
            prescaleNext_s = '0;
        end else if (enable_r) begin
            prescaleNext_s = prescaleCnt_r + PRESCALE_WIDTH'(1'b1);
        end else begin
            prescaleNext_s = prescaleCnt_r;
        end

        if (wrEn && (addr == 5'd0)) begin
            mtimeNext_s = {mtime_r[TIMER_WIDTH-1:32], wrData};
        end else if (wrEn && (addr == 5'd1)) begin
            mtimeNext_s = {wrData[HI_W-1:0], mtime_r[31:0]};
        end else if (tick_s) begin
            mtimeNext_s = mtime_r + TIMER_WIDTH'(1'b1);
        end else begin
            mtimeNext_s = mtime_r;
        end
    end

    // Compare register writes and the per-channel compare terms.
    always_comb begin
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            cmpNext_s[i] = cmp_r[i];
            if (wrEn && (addr == chanAddr(i, 1'b0))) begin
                cmpNext_s[i][31:0] = wrData;
            end else if (wrEn && (addr == chanAddr(i, 1'b1))) begin
                cmpNext_s[i][TIMER_WIDTH-1:32] = wrData[HI_W-1:0];
            end else begin
                cmpNext_s[i] = cmp_r[i];
            end
            irqCmp_s[i] = (mtime_r >= cmp_r[i]);
        end
    end

    // Read mux over pre-edge register values; a LO read captures the upper counter bits.
    always_comb begin
        rdWord_s = 32'h0;
        case (addr)
            5'd0: rdWord_s = mtime_r[31:0];
            5'd1: rdWord_s[HI_W-1:0] = snapshot_r;
            5'd2: begin
                rdWord_s[0]                  = enable_r;
                rdWord_s[16 +: PRESCALE_WIDTH] = div_r;
            end
            5'd3: rdWord_s[NUM_CHANNELS-1:0] = timerIRQ_r;
            default: begin
                for (int i = 0; i < NUM_CHANNELS; i++) begin
                    if (addr == chanAddr(i, 1'b0)) begin
                        rdWord_s = cmp_r[i][31:0];
                    end else if (addr == chanAddr(i, 1'b1)) begin
                        rdWord_s[HI_W-1:0] = cmp_r[i][TIMER_WIDTH-1:32];
                    end else begin
                        rdWord_s = rdWord_s;
                    end
                end
            end
        endcase

        if (rdEn && (addr == 5'd0)) begin
            snapshotNext_s = mtime_r[TIMER_WIDTH-1:32];
        end else begin
            snapshotNext_s = snapshot_r;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtime_r       <= '0;
            enable_r      <= 1'b1;
            div_r         <= '0;
            prescaleCnt_r <= '0;
            snapshot_r    <= '0;
            rdData_r      <= 32'h0;
            rdValid_r     <= 1'b0;
            timerIRQ_r    <= '0;
            irqAny_r      <= 1'b0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                cmp_r[i] <= '1;
            end
        end else begin
            mtime_r       <= mtimeNext_s;
            enable_r      <= enableNext_s;
            div_r         <= divNext_s;
            prescaleCnt_r <= prescaleNext_s;
            snapshot_r    <= snapshotNext_s;
            rdData_r      <= rdEn ? rdWord_s : 32'h0;
            rdValid_r     <= rdEn;
            timerIRQ_r    <= irqCmp_s;
            irqAny_r      <= |irqCmp_s;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                cmp_r[i] <= cmpNext_s[i];
            end
        end
    end

    assign rdData   = rdData_r;
    assign rdValid  = rdValid_r;
    assign timerIRQ = timerIRQ_r;
    assign irqAny   = irqAny_r;
endmodule

// File: doc/io_multi_timer.md
Name: io_multi_timer

Overview:
Parametrised successor to the single mtime/mtimecmp timer in the IO unit. Provides one free-running counter of configurable width with a programmable prescaler and NUM_CHANNELS independent compare channels, each raising a level interrupt. Sits on the IO unit's 32-bit memory-mapped register bus. Exposes every wide register as LO/HI 32-bit words, with an atomic snapshot for counter reads.

Parameters:
NUM_CHANNELS, 2, number of compare channels (legal 1..8)
TIMER_WIDTH, 64, counter and compare width in bits (legal 33..64)
PRESCALE_WIDTH, 16, width of the prescaler divisor field (legal 1..16)

Ports:
clk  input  1  clock
rst  input  1  reset; asynchronous, active-high
wrEn  input  1  register write strobe
rdEn  input  1  register read strobe
addr  input  5  32-bit word address within block
wrData  input  32  write data (DataPath)
rdData  output  32  read data (DataPath)
rdValid  output  1  rdData valid
timerIRQ  output  NUM_CHANNELS  per-channel interrupt, level
irqAny  output  1  OR of timerIRQ

Behaviour:
- Register map (word addr):
  - 0 MTIME_LO
  - 1 MTIME_HI
  - 2 CTRL: bit0 = enable; bits[16+PRESCALE_WIDTH-1:16] = div.
  - 3 STATUS: read-only, bits[NUM_CHANNELS-1:0] = timerIRQ.
  - 4+2i CMP_LO[i], 5+2i CMP_HI[i].
- HI words carry bits [TIMER_WIDTH-1:32]; unused upper bits read 0 and ignore writes.
- Reset values:
  - mtime = 0, every cmp = all ones, enable = 1, div = 0, prescale counter = 0, snapshot = 0.
  - rdData = 0, rdValid = 0, timerIRQ = 0, irqAny = 0.
- Prescaler:
  - While enable = 1, the prescale counter counts 0..div.
  - On the cycle it equals div: counter returns to 0 and mtime increments by 1.
  - div = 0 means mtime increments every cycle.
  - While enable = 0, the prescale counter and mtime hold.
  - A CTRL write clears the prescale counter.
- Wrap-around: mtime wraps from 2^TIMER_WIDTH-1 to 0; no sticky overflow flag.
- Writes (take effect at the clock edge of the strobe):
  - MTIME_LO replaces bits [31:0] only; MTIME_HI replaces the upper bits only. No carry between halves.
  - A write to mtime in the same cycle as an increment: the write wins and that increment is lost. The prescale counter still advances.
  - Writes to STATUS, to unmapped addresses, or to channel index >= NUM_CHANNELS are ignored.
- Reads:
  - One-cycle latency: rdValid = 1 exactly in the cycle after rdEn, with rdData valid in that cycle. rdData = 0 whenever rdValid = 0.
  - A read of MTIME_LO returns low bits and, at the same edge, latches the upper bits into the snapshot. A read of MTIME_HI returns the snapshot, not live mtime.
  - The snapshot is taken from the pre-increment value of that same cycle, so the LO/HI pair is coherent.
  - A MTIME_HI read with no prior LO read returns the current snapshot (0 after reset).
  - CMP and CTRL reads are direct.
  - Unmapped addresses read 0.
  - rdEn and wrEn together to the same address: the read returns the pre-write value.
- Interrupts:
  - timerIRQ[i] is registered as (mtime >= cmp[i]), unsigned, full TIMER_WIDTH, using pre-edge register values. It therefore lags register state by one cycle.
  - Compare is independent of enable.
  - The interrupt is cleared only by raising cmp or lowering mtime; there is no W1C.
  - irqAny is registered, computed from the same pre-edge values as timerIRQ.
- Back-to-back accesses every cycle are legal; no stall or ready signal.
- Reset asserted mid-operation returns all state to reset values immediately (async), including dropping a pending rdValid.

Test Plan:
- Reset, enable = 1, div = 0, run 10 cycles, read MTIME_LO -> rdValid next cycle, rdData = 10 ± access offset (exact value checked by model); MTIME_HI -> 0.
- Write CTRL div = 3, hold 40 cycles -> mtime advances exactly 10; write enable = 0 -> mtime frozen across 20 cycles.
- Write MTIME_HI = 0, MTIME_LO = 0xFFFF_FFFE, read LO at count 0xFFFF_FFFF then HI after the carry -> LO = 0xFFFF_FFFF, HI = 0 (snapshot), next LO/HI pair = 0x1_0000_000x.
- cmp[1] = 100, cmp[0] = all ones, mtime from 0 -> timerIRQ = 2'b10 and irqAny = 1 one cycle after mtime reaches 100; STATUS reads 2; write CMP_LO[1] = 0xFFFF_FFFF, CMP_HI[1] = 0xFFFF_FFFF -> IRQ drops one cycle later.
- Set mtime = 2^64-1, div = 0 -> wraps to 0; a write to MTIME_LO coinciding with an increment -> written value is stored exactly.
- Assert rst while rdEn is pending and IRQ is high -> rdValid, timerIRQ and mtime are 0 immediately; cmp reads back all ones.
